// File: rtl/gf180mcu_sram_banked.sv
// Banked scratch RAM over 512x8 GF180MCU macros: req/ready front end, byte strobes,
// one-hot bank enable, read-data hold register and optional post-reset zero fill.

// Behavioural stand-in for the foundry macro; replace with the hard macro at integration.
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
`ifdef USE_POWER_PINS
  inout              VDD,
  inout              VSS,
`endif
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] mem [512];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int i = 0; i < 8; i++) begin
          if (!WEN[i]) mem[A][i] <= D[i];
        end
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

module gf180mcu_sram_banked #(
  parameter int DATA_WIDTH = 32,
  parameter int BANKS      = 2,
  parameter int INIT_ZERO  = 1,
  localparam int AW = 9 + $clog2(BANKS),
  localparam int NB = DATA_WIDTH / 8
) (
`ifdef USE_POWER_PINS
  inout                         vdd,
  inout                         vss,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  output logic                  ready,
  input  logic                  we,
  input  logic [NB-1:0]         wstrb,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  init_done
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_IDLE  = 1'b1;
  localparam logic ST_RESET = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_width
    $error("gf180mcu_sram_banked: DATA_WIDTH must be a multiple of 8 in 8..64");
  end
  if (BANKS < 1 || BANKS > 8 || (BANKS & (BANKS - 1)) != 0) begin : g_bad_banks
    $error("gf180mcu_sram_banked: BANKS must be a power of 2 in 1..8");
  end

  logic                        state;
  logic [8:0]                  fill_cnt;
  logic                        filling;
  logic                        accept;
  logic [BW-1:0]               bank_sel;
  logic [BW-1:0]               rd_bank;
  logic [DATA_WIDTH-1:0]       hold;
  logic [DATA_WIDTH-1:0]       rd_q;
  logic [BANKS-1:0]            cen;
  logic                        mac_gwen;
  logic [DATA_WIDTH-1:0]       mac_wen;
  logic [8:0]                  mac_a;
  logic [DATA_WIDTH-1:0]       mac_d;
  logic [BANKS*DATA_WIDTH-1:0] q_flat;

  if (BANKS > 1) begin : g_bank_dec
    assign bank_sel = addr[AW-1:9];
  end else begin : g_single_bank
    assign bank_sel = 1'b0;
  end

  // ready also follows the reset pin so nothing is accepted while reset is held.
  assign filling = (state == ST_INIT);
  assign ready   = reset & (state == ST_IDLE);
  assign accept  = req & ready;

  always_comb begin
    cen = '1;
    for (int b = 0; b < BANKS; b++) begin
      if (filling) cen[b] = ~reset;
      else         cen[b] = ~(accept && (bank_sel == BW'(b)));
    end
  end

  always_comb begin
    mac_a    = filling ? fill_cnt : addr[8:0];
    mac_gwen = filling ? 1'b0 : ~(we & (|wstrb));
    mac_d    = filling ? '0 : wdata;
    mac_wen  = '0;
    for (int i = 0; i < NB; i++) begin
      mac_wen[8*i +: 8] = filling ? 8'h00 : {8{~(we & wstrb[i])}};
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    for (genvar l = 0; l < NB; l++) begin : g_lane
      gf180mcu_fd_ip_sram__sram512x8m8wm1 u_mac (
`ifdef USE_POWER_PINS
        .VDD  (vdd),
        .VSS  (vss),
`endif
        .CLK  (clk),
        .CEN  (cen[b]),
        .GWEN (mac_gwen),
        .WEN  (mac_wen[8*l +: 8]),
        .A    (mac_a),
        .D    (mac_d[8*l +: 8]),
        .Q    (q_flat[(b*NB + l)*8 +: 8])
      );
    end
  end

  always_comb begin
    rd_q = q_flat[DATA_WIDTH-1:0];
    for (int b = 0; b < BANKS; b++) begin
      if (rd_bank == BW'(b)) rd_q = q_flat[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Macro Q is only trusted in the rvalid cycle; afterwards the hold copy is shown.
  assign rdata = rvalid ? rd_q : hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RESET;
      fill_cnt  <= 9'd0;
      init_done <= 1'b0;
      rvalid    <= 1'b0;
      rd_bank   <= '0;
      hold      <= '0;
    end else begin
      if (filling) begin
        fill_cnt <= fill_cnt + 9'd1;
        if (fill_cnt == 9'd511) state <= ST_IDLE;
      end
      if (state == ST_IDLE || (filling && fill_cnt == 9'd511)) init_done <= 1'b1;
      rvalid <= accept & ~we;
      if (accept) rd_bank <= bank_sel;
      if (rvalid) hold <= rdata;
    end
  end

endmodule

// File: tb/tb_gf180mcu_sram_banked.sv
// Bench for gf180mcu_sram_banked: default 32x1024 zero-fill instance driven from a vector
// table and hand sequences, plus a 16-bit single-bank no-fill instance under random traffic.
module tb_gf180mcu_sram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, we_a, ready_a, rvalid_a, init_done_a;
  logic [3:0]  wstrb_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;

  logic        rst_b, req_b, we_b, ready_b, rvalid_b, init_done_b;
  logic [1:0]  wstrb_b;
  logic [8:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;

  gf180mcu_sram_banked #(.DATA_WIDTH(32), .BANKS(2), .INIT_ZERO(1)) u_a (
    .clk(clk), .reset(rst_a), .req(req_a), .ready(ready_a), .we(we_a), .wstrb(wstrb_a),
    .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .rvalid(rvalid_a), .init_done(init_done_a)
  );

  gf180mcu_sram_banked #(.DATA_WIDTH(16), .BANKS(1), .INIT_ZERO(0)) u_b (
    .clk(clk), .reset(rst_b), .req(req_b), .ready(ready_b), .we(we_b), .wstrb(wstrb_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .rvalid(rvalid_b), .init_done(init_done_b)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  strb;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  cen;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[$];

  int n_vec = 0;
  int n_err = 0;
  int hi_cnt;

  logic [15:0] mem_b [512];
  logic [15:0] exp_rd_b;
  logic        exp_rv_b;
  int unsigned op;
  logic [8:0]  ra;
  logic [1:0]  rs;
  logic [15:0] rd16;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_a();
    req_a = 1'b0; we_a = 1'b0; wstrb_a = '0; addr_a = '0; wdata_a = '0;
  endtask

  // Samples cycles 1..512 after reset release; expects ready/init_done low throughout
  // and both high in cycle 513.
  task automatic check_fill(input string tag);
    hi_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (ready_a || init_done_a) hi_cnt++;
      @(negedge clk); #1;
    end
    check({tag, "_busy_cycles"}, 64'(hi_cnt), 64'(0));
    check({tag, "_ready_513"}, 64'(ready_a), 64'(1));
    check({tag, "_init_done_513"}, 64'(init_done_a), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           req  we   strb  addr     wdata         cen    rv   rdata next cycle
    tv.push_back('{1'b1,1'b0,4'h0,10'h3FF,32'h0,        2'b01,1'b1,32'h00000000});
    tv.push_back('{1'b1,1'b1,4'hF,10'h005,32'h11223344, 2'b10,1'b0,32'h00000000});
    tv.push_back('{1'b1,1'b1,4'h5,10'h005,32'hAABBCCDD, 2'b10,1'b0,32'h00000000});
    tv.push_back('{1'b1,1'b0,4'h0,10'h005,32'h0,        2'b10,1'b1,32'h11BB33DD});
    tv.push_back('{1'b1,1'b1,4'hF,10'h010,32'hDEADBEEF, 2'b10,1'b0,32'h11BB33DD});
    tv.push_back('{1'b1,1'b1,4'hF,10'h210,32'hCAFEF00D, 2'b01,1'b0,32'h11BB33DD});
    tv.push_back('{1'b1,1'b0,4'h0,10'h010,32'h0,        2'b10,1'b1,32'hDEADBEEF});
    tv.push_back('{1'b1,1'b0,4'h0,10'h210,32'h0,        2'b01,1'b1,32'hCAFEF00D});
    tv.push_back('{1'b0,1'b0,4'h0,10'h000,32'h0,        2'b11,1'b0,32'hCAFEF00D});
    tv.push_back('{1'b1,1'b0,4'h0,10'h005,32'h0,        2'b10,1'b1,32'h11BB33DD});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1'b0,1'b0,4'h0,10'h000,32'h0,      2'b11,1'b0,32'h11BB33DD});
    tv.push_back('{1'b1,1'b1,4'hF,10'h005,32'h55555555, 2'b10,1'b0,32'h11BB33DD});
    tv.push_back('{1'b0,1'b0,4'h0,10'h000,32'h0,        2'b11,1'b0,32'h11BB33DD});
    tv.push_back('{1'b1,1'b1,4'h0,10'h005,32'h0,        2'b10,1'b0,32'h11BB33DD});
    tv.push_back('{1'b1,1'b0,4'h0,10'h005,32'h0,        2'b10,1'b1,32'h55555555});
    tv.push_back('{1'b1,1'b0,4'h0,10'h3FF,32'h0,        2'b01,1'b1,32'h00000000});
    tv.push_back('{1'b1,1'b1,4'hF,10'h3FF,32'h01020304, 2'b01,1'b0,32'h00000000});
    tv.push_back('{1'b1,1'b0,4'h0,10'h3FF,32'h0,        2'b01,1'b1,32'h01020304});

    rst_a = 1'b0; rst_b = 1'b0;
    idle_a();
    req_b = 1'b0; we_b = 1'b0; wstrb_b = '0; addr_b = '0; wdata_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready_a", 64'(ready_a), 64'(0));
    check("rst_rvalid_a", 64'(rvalid_a), 64'(0));
    check("rst_rdata_a", 64'(rdata_a), 64'(0));
    check("rst_init_done_a", 64'(init_done_a), 64'(0));
    check("rst_ready_b", 64'(ready_b), 64'(0));
    check("rst_init_done_b", 64'(init_done_b), 64'(0));

    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("nofill_ready_first_cycle", 64'(ready_b), 64'(1));
    check_fill("init");
    check("nofill_init_done_b", 64'(init_done_b), 64'(1));

    foreach (tv[i]) begin
      req_a = tv[i].req; we_a = tv[i].we; wstrb_a = tv[i].strb;
      addr_a = tv[i].addr; wdata_a = tv[i].wdata;
      #1;
      check($sformatf("vec%0d_cen", i), 64'(u_a.cen), 64'(tv[i].cen));
      check($sformatf("vec%0d_ready", i), 64'(ready_a), 64'(1));
      @(negedge clk); #1;
      check($sformatf("vec%0d_rvalid", i), 64'(rvalid_a), 64'(tv[i].rv));
      check($sformatf("vec%0d_rdata", i), 64'(rdata_a), 64'(tv[i].rd));
    end
    idle_a();

    // Reset lands just after a read was accepted: the pulse must never be seen.
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'h010;
    @(posedge clk); #1;
    rst_a = 1'b0;
    #1;
    check("midrst_rvalid", 64'(rvalid_a), 64'(0));
    check("midrst_rdata", 64'(rdata_a), 64'(0));
    check("midrst_cen", 64'(u_a.cen), 64'(2'b11));
    check("midrst_ready", 64'(ready_a), 64'(0));
    @(negedge clk); #1;
    check("midrst_rvalid_later", 64'(rvalid_a), 64'(0));
    check("midrst_rdata_later", 64'(rdata_a), 64'(0));
    idle_a();
    rst_a = 1'b1;
    #1;
    check_fill("refill");
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'h010;
    @(negedge clk); #1;
    idle_a();
    check("refill_read_rvalid", 64'(rvalid_a), 64'(1));
    check("refill_read_rdata", 64'(rdata_a), 64'(0));

    // Narrow instance: define every word first, then random mixed traffic.
    exp_rd_b = '0;
    for (int a = 0; a < 512; a++) begin
      rd16 = 16'($urandom);
      req_b = 1'b1; we_b = 1'b1; wstrb_b = 2'b11; addr_b = 9'(a); wdata_b = rd16;
      mem_b[a] = rd16;
      @(negedge clk); #1;
    end
    req_b = 1'b0;
    @(negedge clk); #1;
    check("prefill_rvalid_b", 64'(rvalid_b), 64'(0));
    check("prefill_rdata_b", 64'(rdata_b), 64'(0));

    for (int k = 0; k < 2000; k++) begin
      op = $urandom_range(0, 9);
      ra = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
      rs = 2'($urandom_range(0, 3));
      rd16 = 16'($urandom);
      exp_rv_b = 1'b0;
      req_b = (op >= 2); we_b = (op >= 6); wstrb_b = rs; addr_b = ra; wdata_b = rd16;
      if (op >= 2 && op < 6) begin
        exp_rv_b = 1'b1;
        exp_rd_b = mem_b[ra];
      end else if (op >= 6) begin
        if (rs[0]) mem_b[ra][7:0]  = rd16[7:0];
        if (rs[1]) mem_b[ra][15:8] = rd16[15:8];
      end
      #1;
      check("rand_ready_b", 64'(ready_b), 64'(1));
      @(negedge clk); #1;
      check($sformatf("rand%0d_rvalid", k), 64'(rvalid_b), 64'(exp_rv_b));
      check($sformatf("rand%0d_rdata", k), 64'(rdata_b), 64'(exp_rd_b));
    end
    req_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
